// File: rtl/local_ctrl_ring_scheduler.sv
// Command queue feeding one-hot config/prefetch pulses to four local controllers,
// with a fixed idle gap between pulses. Prefetch support: LOCAL_CTRL_SCHED_PREFETCH_EN.
module local_ctrl_ring_scheduler #(
  parameter int sample_address_width = 8,
  parameter int address_vector_width = 8,
  parameter int FIFO_DEPTH           = 4,
  parameter int GAP_CYCLES           = 2
) (
  input  logic                            CLK,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_type,
  input  logic [1:0]                      cmd_id,
  input  logic [sample_address_width-1:0] cmd_a,
  input  logic [sample_address_width-1:0] cmd_b,
  input  logic [address_vector_width-1:0] cmd_dest,
  output logic [3:0]                      ctrl_valid,
  output logic [sample_address_width-1:0] ctrl_delay,
  output logic [address_vector_width-1:0] ctrl_dest,
  output logic [3:0]                      pref_valid,
  output logic [sample_address_width-1:0] pref_start,
  output logic [sample_address_width-1:0] pref_stop,
  output logic [address_vector_width-1:0] pref_dest,
  output logic                            busy,
  output logic                            err_drop
);
  localparam int SA = sample_address_width;
  localparam int AV = address_vector_width;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
`ifdef LOCAL_CTRL_SCHED_PREFETCH_EN
  localparam bit PREF_EN = 1'b1;
`else
  localparam bit PREF_EN = 1'b0;
`endif

  typedef struct packed {
    logic          typ;
    logic [1:0]    id;
    logic [SA-1:0] a;
    logic [SA-1:0] b;
    logic [AV-1:0] dest;
  } entry_t;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_t;

  entry_t        mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r, count_nxt_s;
  state_t        state_r, state_nxt_s;
  logic [3:0]    gap_cnt_r, gap_nxt_s;
  logic          ready_r, busy_r, err_drop_r;
  logic [3:0]    ctrl_valid_r;
  logic [SA-1:0] ctrl_delay_r;
  logic [AV-1:0] ctrl_dest_r;
  logic          push_s, pop_s, slot_s, drop_s, issue_s;
  entry_t        head_s, in_s;

  assign in_s    = '{typ: cmd_type, id: cmd_id, a: cmd_a, b: cmd_b, dest: cmd_dest};
  assign head_s  = mem_r[rd_ptr_r];
  assign push_s  = cmd_valid && ready_r;
  // Prefetch commands are rejected outright when the feature is compiled out.
  assign drop_s  = head_s.typ && (!PREF_EN || (head_s.a > head_s.b));
  assign issue_s = pop_s && !drop_s;

  // Next-state logic: a pop slot opens in IDLE, after ISSUE with no gap, or on the last GAP cycle.
  always_comb begin
    state_nxt_s = state_r;
    gap_nxt_s   = gap_cnt_r;
    pop_s       = 1'b0;
    slot_s      = 1'b0;
    case (state_r)
      IDLE:  slot_s = 1'b1;
      ISSUE: begin
        if (GAP_CYCLES == 0) begin
          slot_s = 1'b1;
        end else begin
          state_nxt_s = GAP;
          gap_nxt_s   = 4'd0;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          slot_s = 1'b1;
        end else begin
          gap_nxt_s = gap_cnt_r + 4'd1;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
    if (slot_s) begin
      gap_nxt_s = 4'd0;
      if (count_r != CW'(0)) begin
        pop_s       = 1'b1;
        state_nxt_s = drop_s ? IDLE : ISSUE;
      end else begin
        state_nxt_s = IDLE;
      end
    end else begin
      pop_s = 1'b0;
    end
  end

  // Occupancy after this edge's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Queue storage; entries are only read after being written, so no reset needed.
  always_ff @(posedge CLK) begin
    if (push_s) mem_r[wr_ptr_r] <= in_s;
  end

  // Control state, queue pointers and registered config outputs.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      gap_cnt_r    <= 4'd0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      ready_r      <= 1'b0;
      busy_r       <= 1'b0;
      err_drop_r   <= 1'b0;
      ctrl_valid_r <= 4'd0;
      ctrl_delay_r <= '0;
      ctrl_dest_r  <= '0;
    end else begin
      state_r    <= state_nxt_s;
      gap_cnt_r  <= gap_nxt_s;
      count_r    <= count_nxt_s;
      ready_r    <= (count_nxt_s != CW'(FIFO_DEPTH));
      busy_r     <= (count_nxt_s != CW'(0)) || (state_nxt_s != IDLE);
      err_drop_r <= pop_s && drop_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      if (issue_s && !head_s.typ) begin
        ctrl_valid_r <= 4'b0001 << head_s.id;
        ctrl_delay_r <= head_s.a;
        ctrl_dest_r  <= head_s.dest;
      end else begin
        ctrl_valid_r <= 4'd0;
        ctrl_delay_r <= '0;
        ctrl_dest_r  <= '0;
      end
    end
  end

`ifdef LOCAL_CTRL_SCHED_PREFETCH_EN
  logic [3:0]    pref_valid_r;
  logic [SA-1:0] pref_start_r, pref_stop_r;
  logic [AV-1:0] pref_dest_r;

  // Registered prefetch pulse and payload.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      pref_valid_r <= 4'd0;
      pref_start_r <= '0;
      pref_stop_r  <= '0;
      pref_dest_r  <= '0;
    end else if (issue_s && head_s.typ) begin
      pref_valid_r <= 4'b0001 << head_s.id;
      pref_start_r <= head_s.a;
      pref_stop_r  <= head_s.b;
      pref_dest_r  <= head_s.dest;
    end else begin
      pref_valid_r <= 4'd0;
      pref_start_r <= '0;
      pref_stop_r  <= '0;
      pref_dest_r  <= '0;
    end
  end

  assign pref_valid = pref_valid_r;
  assign pref_start = pref_start_r;
  assign pref_stop  = pref_stop_r;
  assign pref_dest  = pref_dest_r;
`else
  assign pref_valid = 4'd0;
  assign pref_start = {SA{1'b0}};
  assign pref_stop  = {SA{1'b0}};
  assign pref_dest  = {AV{1'b0}};
`endif

  assign cmd_ready  = ready_r;
  assign busy       = busy_r;
  assign err_drop   = err_drop_r;
  assign ctrl_valid = ctrl_valid_r;
  assign ctrl_delay = ctrl_delay_r;
  assign ctrl_dest  = ctrl_dest_r;
endmodule
